// File: rtl/instr_fetch_unit.sv
// Fetch stage for the unpipelined MIPS core.
// Holds the PC, issues one instruction-memory request per instruction,
// waits for the returned word (re-requesting after a bounded wait), presents
// it to the decoder while execute runs, then selects the next PC from the
// decoder's jump/beq/bne outputs and the ALU zero flag.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imemReq,
   output logic [31:0] o_imemAddr,
   input  logic        i_imemValid,
   input  logic [31:0] i_imemData,
   output logic [31:0] o_instr,
   output logic        o_instrValid,
   input  logic        i_exDone,
   input  logic        i_jump,
   input  logic        i_beq,
   input  logic        i_bne,
   input  logic        i_zero,
   output logic [31:0] o_pc,
   output logic [31:0] o_pcPlus4,
   output logic        o_fetchErr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_EXEC  = 2'd3
   } state_t;

   // Last counter value before a request is abandoned and re-issued.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_err;
   logic [7:0]  r_cnt;

   logic        w_capture;
   logic        w_timeout;
   logic        w_loadPc;
   logic        w_clrCnt;
   logic        w_incCnt;

   logic [31:0] w_pcPlus4;
   logic [31:0] w_brOff;
   logic [31:0] w_brTarget;
   logic [31:0] w_jTarget;
   logic [31:0] w_pcNext;

   // Sequential-PC and target arithmetic; all sums wrap modulo 2^32.
   assign w_pcPlus4  = r_pc + 32'd4;
   assign w_brOff    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
   assign w_brTarget = w_pcPlus4 + w_brOff;
   assign w_jTarget  = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};

   // Next-PC select: jump wins, then beq (taken on zero), then bne (taken on !zero).
   always_comb begin
      w_pcNext = w_pcPlus4;
      if (i_jump) begin
         w_pcNext = w_jTarget;
      end else if (i_beq && i_zero) begin
         w_pcNext = w_brTarget;
      end else if (i_bne && !i_zero) begin
         w_pcNext = w_brTarget;
      end
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state control strobes; memory valid only counts in WAIT,
   // and valid beats the timeout when both land in the same cycle.
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_timeout = 1'b0;
      w_loadPc  = 1'b0;
      w_clrCnt  = 1'b0;
      w_incCnt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_next = S_FETCH;
         end
         S_FETCH: begin
            w_clrCnt = 1'b1;
            w_next   = S_WAIT;
         end
         S_WAIT: begin
            w_incCnt = 1'b1;
            if (i_imemValid) begin
               w_capture = 1'b1;
               w_next    = S_EXEC;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout = 1'b1;
               w_next    = S_FETCH;
            end
         end
         S_EXEC: begin
            if (i_exDone) begin
               w_loadPc = 1'b1;
               w_next   = S_FETCH;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // PC update, only when execute signals completion.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc <= RESET_PC;
      end else if (w_loadPc) begin
         r_pc <= w_pcNext;
      end
   end

   // Instruction holding register, loaded once per fetch.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_instr <= 32'd0;
      end else if (w_capture) begin
         r_instr <= i_imemData;
      end
   end

   // Wait-cycle counter: cleared in FETCH, counts every WAIT cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
      end else if (w_clrCnt) begin
         r_cnt <= 8'd0;
      end else if (w_incCnt) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Sticky fetch-error flag, cleared only by reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else if (w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign o_imemReq    = (r_state == S_FETCH);
   assign o_instrValid = (r_state == S_EXEC);
   assign o_imemAddr   = r_pc;
   assign o_pc         = r_pc;
   assign o_pcPlus4    = w_pcPlus4;
   assign o_instr      = r_instr;
   assign o_fetchErr   = r_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of instructions is run
// through a memory/execute model; expected fetch addresses go into a queue
// when each instruction completes and are compared at the next request.
module tb_instr_fetch_unit;

   localparam int TO = 16;

   typedef struct {
      logic [31:0] data;
      logic        jump;
      logic        beq;
      logic        bne;
      logic        zero;
      int          lat;
      int          exw;
      logic [31:0] nxt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemValid, exDone, jump, beq, bne, zero;
   logic [31:0] imemData;
   logic        imemReq, instrValid, fetchErr;
   logic [31:0] imemAddr, instr, pc, pcPlus4;
   logic        hi_imemReq, hi_instrValid, hi_fetchErr;
   logic [31:0] hi_imemAddr, hi_instr, hi_pc, hi_pcPlus4;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic        exp_err;
   vec_t        tbl[15];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) u_dut (
      .i_clk(clk), .i_rst(rst),
      .o_imemReq(imemReq), .o_imemAddr(imemAddr),
      .i_imemValid(imemValid), .i_imemData(imemData),
      .o_instr(instr), .o_instrValid(instrValid),
      .i_exDone(exDone), .i_jump(jump), .i_beq(beq), .i_bne(bne), .i_zero(zero),
      .o_pc(pc), .o_pcPlus4(pcPlus4), .o_fetchErr(fetchErr)
   );

   // Second copy in lockstep, reset into the upper address region for the jump test.
   instr_fetch_unit #(.RESET_PC(32'h3000_0000), .TIMEOUT(TO)) u_hi (
      .i_clk(clk), .i_rst(rst),
      .o_imemReq(hi_imemReq), .o_imemAddr(hi_imemAddr),
      .i_imemValid(imemValid), .i_imemData(imemData),
      .o_instr(hi_instr), .o_instrValid(hi_instrValid),
      .i_exDone(exDone), .i_jump(jump), .i_beq(beq), .i_bne(bne), .i_zero(zero),
      .o_pc(hi_pc), .o_pcPlus4(hi_pcPlus4), .o_fetchErr(hi_fetchErr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [31:0] d, input logic j, input logic b,
                               input logic n, input logic z, input int lat,
                               input int exw, input logic [31:0] nxt);
      vec_t v;
      v.data = d; v.jump = j; v.beq = b; v.bne = n; v.zero = z;
      v.lat = lat; v.exw = exw; v.nxt = nxt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // Waits (bounded) for a request and compares its address with the queue head.
   task automatic wait_req(output int rc);
      int n;
      logic [31:0] e;
      n = 0;
      while (imemReq !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", {31'd0, imemReq}, 32'd1);
      rc = cyc;
      if (q.size() == 0) begin
         chk("queue_nonempty", 32'd0, 32'd1);
         e = 32'hxxxx_xxxx;
      end else begin
         e = q.pop_front();
      end
      chk("req_addr", imemAddr, e);
      chk("pc_plus4", pcPlus4, e + 32'd4);
      chk("valid_low_fetch", {31'd0, instrValid}, 32'd0);
      chk("fetch_err", {31'd0, fetchErr}, {31'd0, exp_err});
   endtask

   task automatic run_instr(input vec_t v, output int rc);
      wait_req(rc);
      @(negedge clk);
      // extra WAIT cycles; a stray exDone/jump here must be ignored
      for (int k = 1; k < v.lat; k++) begin
         chk("wait_req_low", {31'd0, imemReq}, 32'd0);
         chk("wait_valid_low", {31'd0, instrValid}, 32'd0);
         exDone = 1'b1; jump = 1'b1;
         @(negedge clk);
      end
      exDone = 1'b0; jump = 1'b0;
      imemValid = 1'b1; imemData = v.data;
      @(negedge clk);
      imemValid = 1'b0; imemData = $urandom;
      chk("exec_valid", {31'd0, instrValid}, 32'd1);
      chk("exec_instr", instr, v.data);
      for (int k = 0; k < v.exw; k++) begin
         @(negedge clk);
         chk("exec_hold_valid", {31'd0, instrValid}, 32'd1);
         chk("exec_hold_instr", instr, v.data);
      end
      exDone = 1'b1; jump = v.jump; beq = v.beq; bne = v.bne; zero = v.zero;
      q.push_back(v.nxt);
      @(negedge clk);
      exDone = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;
   endtask

   initial begin
      int rc, rc0, rc1, rc2;
      rst = 1'b1; imemValid = 1'b0; imemData = '0;
      exDone = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; zero = 1'b0;

      //              data          j     beq   bne   zero  lat exw next
      tbl[0]  = mk(32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b1, 1,  0, 32'h0000_0400);
      tbl[1]  = mk(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1,  0, 32'h0000_0010);
      tbl[2]  = mk(32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b1, 1,  0, 32'h0000_0020);
      tbl[3]  = mk(32'h0800_0004, 1'b1, 1'b0, 1'b0, 1'b0, 2,  0, 32'h0000_0010);
      tbl[4]  = mk(32'h1000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1, 32'h0000_0014);
      tbl[5]  = mk(32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1,  0, 32'h0000_0040);
      tbl[6]  = mk(32'h1400_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1,  0, 32'h0000_0040);
      tbl[7]  = mk(32'h1400_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0, 32'h0000_0044);
      tbl[8]  = mk(32'h1000_0002, 1'b0, 1'b1, 1'b1, 1'b0, 1,  0, 32'h0000_0050);
      tbl[9]  = mk(32'h1000_0001, 1'b0, 1'b1, 1'b1, 1'b1, 1,  0, 32'h0000_0058);
      tbl[10] = mk(32'h0800_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1,  0, 32'h0000_0000);
      tbl[11] = mk(32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1,  0, 32'hFFFF_FFFC);
      tbl[12] = mk(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 2,  2, 32'h0000_0000);
      tbl[13] = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, TO, 0, 32'h0000_0004);
      tbl[14] = mk(32'h1400_0005, 1'b0, 1'b0, 1'b1, 1'b1, 1,  1, 32'h0000_0008);

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc4", pcPlus4, 32'h4);
      chk("rst_addr", imemAddr, 32'h0);
      chk("rst_req", {31'd0, imemReq}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ivalid", {31'd0, instrValid}, 32'd0);
      chk("rst_err", {31'd0, fetchErr}, 32'd0);
      chk("rst_hi_pc", hi_pc, 32'h3000_0000);
      exp_err = 1'b0;
      q.push_back(32'h0);
      rst = 1'b0;

      // jump with beq also high, checked on both copies
      run_instr(tbl[0], rc);
      chk("hi_jump_req", {31'd0, hi_imemReq}, 32'd1);
      chk("hi_jump_addr", hi_imemAddr, 32'h3000_0400);

      for (int i = 1; i < 15; i++) run_instr(tbl[i], rc);

      // timeout: valid withheld TO cycles at PC 0x8, then re-request
      wait_req(rc);
      for (int k = 0; k < TO; k++) begin
         @(negedge clk);
         chk("to_wait_req", {31'd0, imemReq}, 32'd0);
         chk("to_err_before", {31'd0, fetchErr}, 32'd0);
      end
      @(negedge clk);
      chk("to_rereq", {31'd0, imemReq}, 32'd1);
      chk("to_rereq_addr", imemAddr, 32'h8);
      chk("to_err_set", {31'd0, fetchErr}, 32'd1);
      exp_err = 1'b1;
      q.push_back(32'h8);
      run_instr(mk(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0000_000C), rc);

      // reset mid-WAIT with a late valid pending
      wait_req(rc);
      @(negedge clk);
      rst = 1'b1; imemValid = 1'b1; imemData = 32'hDEAD_BEEF;
      #1;
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_addr", imemAddr, 32'h0);
      chk("mid_rst_req", {31'd0, imemReq}, 32'd0);
      chk("mid_rst_instr", instr, 32'h0);
      chk("mid_rst_ivalid", {31'd0, instrValid}, 32'd0);
      chk("mid_rst_err", {31'd0, fetchErr}, 32'd0);
      @(negedge clk);
      chk("mid_rst_ivalid2", {31'd0, instrValid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      q.delete();
      q.push_back(32'h0);
      exp_err = 1'b0;

      // back-to-back minimum-length loops: 0x0, 0x4, 0x8 three cycles apart
      run_instr(mk(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 32'h4), rc0);
      run_instr(mk(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 32'h8), rc1);
      run_instr(mk(32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 32'hC), rc2);
      chk("spacing_01", rc1 - rc0, 32'd3);
      chk("spacing_12", rc2 - rc1, 32'd3);
      wait_req(rc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the unpipelined MIPS core; sits directly upstream of the control decoder.
- Holds the PC and fetches one instruction at a time from instruction memory over a request/valid handshake.
- Presents the instruction (opcode field drives the decoder) until execute reports completion.
- Then computes the next PC from the decoder's jump/beq/bne outputs and the ALU zero flag.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
TIMEOUT, 16, max cycles spent waiting for i_imemValid before the request is re-issued; range 1..255.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous, active-high reset
o_imemReq  output  1  fetch request strobe, one cycle per request
o_imemAddr  output  32  fetch address, equals o_pc
i_imemValid  input  1  instruction memory data valid
i_imemData  input  32  instruction word, sampled when i_imemValid is high in WAIT
o_instr  output  32  held instruction; [31:26] feeds decoder opcode input
o_instrValid  output  1  o_instr is valid and executing
i_exDone  input  1  execute/writeback complete; branch inputs valid this cycle
i_jump  input  1  from decoder
i_beq  input  1  from decoder
i_bne  input  1  from decoder
i_zero  input  1  ALU zero flag
o_pc  output  32  current PC
o_pcPlus4  output  32  o_pc + 4, modulo 2^32
o_fetchErr  output  1  sticky: at least one fetch timeout since reset

Behaviour:
- Reset (async, i_rst=1), immediate values:
  - state=IDLE, o_pc=RESET_PC, o_instr=0, o_instrValid=0, o_imemReq=0, o_fetchErr=0, timeout counter=0.
  - Reset asserted in any state aborts the operation; a late i_imemValid after reset is ignored unless the FSM is in WAIT.
- FSM, one transition per clock:
  - IDLE: -> FETCH.
  - FETCH: o_imemReq=1 (Moore); o_imemAddr=o_pc; counter cleared. i_imemValid is ignored in FETCH (memory latency >= 1). -> WAIT.
  - WAIT: o_imemReq=0; counter increments each cycle.
    - If i_imemValid=1: capture i_imemData into o_instr; -> EXEC.
    - Else if counter == TIMEOUT-1: set o_fetchErr; -> FETCH (same PC re-requested).
    - Valid takes priority over timeout when both occur in the same cycle.
  - EXEC: o_instrValid=1; o_instr held stable.
    - If i_exDone=1: load the next PC; -> FETCH.
    - i_exDone in any other state is ignored.
- Next-PC on i_exDone, priority order:
  1. i_jump=1: {o_pcPlus4[31:28], o_instr[25:0], 2'b00}.
  2. i_beq=1 and i_zero=1: o_pcPlus4 + {{14{o_instr[15]}}, o_instr[15:0], 2'b00}.
  3. i_bne=1 and i_zero=0: same branch target as (2).
  4. Otherwise: o_pcPlus4.
- Next-PC rules and corner cases:
  - All additions are 32-bit, wrap modulo 2^32; carry discarded.
  - If i_beq and i_bne are both high (illegal decode), i_beq is evaluated first. If beq is not taken, bne is then evaluated.
  - A jump with i_beq/i_bne also high is a jump.
  - Inputs at x/z (decoder drives z on some fields) are a don't-care only for signals not listed above.
  - i_jump/i_beq/i_bne must be 0/1 when i_exDone=1.
  - PC bits [1:0] stay 0 under all paths.
- o_instrValid drops in the cycle after i_exDone is sampled, i.e. in FETCH.
- Minimum loop length is 3 cycles per instruction: FETCH, WAIT with valid, EXEC with exDone.
- o_pcPlus4 and o_imemAddr are combinational from the PC register.

Test Plan:
- Reset release, memory latency 1 (valid the cycle after req), exDone in the first EXEC cycle -> req at addr 0x0, then 0x4, then 0x8. Requests spaced 3 cycles apart; o_instrValid high one cycle each.
- Instr 0x1000_0003 at PC 0x10, i_beq=1, i_zero=1 at exDone -> next o_imemAddr=0x20. Same with i_zero=0 -> 0x14.
- Instr 0x1400_FFFF at PC 0x40, i_bne=1, i_zero=0 -> next PC 0x40.
- Instr 0x0800_0100 at PC 0x3000_0000, i_jump=1 (with i_beq=1 also high) -> next PC 0x3000_0400.
- Valid withheld TIMEOUT cycles -> o_fetchErr=1, second req to the same address. Valid then arrives -> normal EXEC. o_fetchErr stays 1 until reset.
- PC 0xFFFF_FFFC, no branch -> next PC 0x0. Reset asserted mid-WAIT -> outputs return to reset values immediately; first req after release at RESET_PC.
